// File: rtl/encoder_scan_n.sv
// rtl/encoder_scan_n.sv - sequential N-to-log2(N) encoder emitting every set bit index, lowest first
// Optional ENC_ONEHOT_CHK_EN adds onehot_err, a one-cycle flag for multi-bit captures.
module encoder_scan_n #(
    parameter int N_LINES   = 8,
    parameter int OUT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_LINES-1:0]   in_lines,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_lines,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 zero_err,
    output logic                 busy
`ifdef ENC_ONEHOT_CHK_EN
    ,
    output logic                 onehot_err
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N_LINES-1:0]   pending_q, pending_d;
    logic                 zero_err_q, zero_err_d;

    logic                 in_fire;
    logic                 out_fire;
    logic [N_LINES-1:0]   lowest_mask;
    logic                 pending_single;
    logic                 in_multi;
    logic [OUT_WIDTH-1:0] low_idx;

    // Isolate the lowest set bit; a single-bit vector is one whose lowest bit is all of it.
    assign lowest_mask    = pending_q & (~pending_q + N_LINES'(1));
    assign pending_single = (pending_q != '0) && (pending_q == lowest_mask);
    assign in_multi       = (in_lines & (in_lines - N_LINES'(1))) != '0;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        low_idx = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = OUT_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            zero_err_q <= zero_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (in_lines == '0) begin
                        zero_err_d = 1'b1;
                    end else begin
                        pending_d = in_lines;
                        state_d   = SCAN;
                    end
                end
            end
            SCAN: begin
                if (out_fire) begin
                    pending_d = pending_q & ~lowest_mask;
                    if (pending_single) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // Reset gates the handshake outputs so a held-high rst never looks ready or valid.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_lines = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                end
                SCAN: begin
                    out_valid = 1'b1;
                    busy      = 1'b1;
                    out_lines = low_idx;
                    out_last  = pending_single;
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

    assign zero_err = zero_err_q;

`ifdef ENC_ONEHOT_CHK_EN
    logic onehot_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_err_q <= 1'b0;
        end else begin
            onehot_err_q <= in_fire && (state_q == IDLE) && in_multi;
        end
    end

    assign onehot_err = onehot_err_q;
`else
    logic unused_in_multi;
    assign unused_in_multi = in_multi;
`endif

endmodule

// File: tb/tb_encoder_scan_n.sv
// tb/tb_encoder_scan_n.sv - directed-vector bench for encoder_scan_n (N_LINES=8)
module tb_encoder_scan_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_lines;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_lines;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       zero_err;
    logic       busy;
`ifdef ENC_ONEHOT_CHK_EN
    logic       onehot_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    encoder_scan_n #(.N_LINES(8), .OUT_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_lines  (in_lines),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_lines (out_lines),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .zero_err  (zero_err),
        .busy      (busy)
`ifdef ENC_ONEHOT_CHK_EN
        ,
        .onehot_err(onehot_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] v);
        in_lines = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_idx [4];
        exp_idx[0] = 3'd0;
        exp_idx[1] = 3'd2;
        exp_idx[2] = 3'd5;
        exp_idx[3] = 3'd7;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_lines  = 8'hFF;
        out_ready = 1'b0;

        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_lines", out_lines, 0);
            check("rst_zero_err", zero_err, 0);
            check("rst_busy", busy, 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);

        out_ready = 1'b1;
        capture(8'b0000_1000);
        check("single_valid", out_valid, 1);
        check("single_idx", out_lines, 3);
        check("single_last", out_last, 1);
        check("single_busy", busy, 1);
        check("single_in_ready", in_ready, 0);
        step();
        check("single_done_valid", out_valid, 0);
        check("single_done_in_ready", in_ready, 1);

        capture(8'b1010_0101);
        in_valid = 1'b1;
        in_lines = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            check("multi_valid", out_valid, 1);
            check("multi_idx", out_lines, exp_idx[i]);
            check("multi_last", out_last, (i == 3) ? 1 : 0);
            check("multi_in_ready", in_ready, 0);
`ifdef ENC_ONEHOT_CHK_EN
            check("multi_onehot_err", onehot_err, (i == 0) ? 1 : 0);
`endif
            if (i == 3) in_valid = 1'b0;
            step();
        end
        check("multi_done_valid", out_valid, 0);
        check("multi_done_in_ready", in_ready, 1);

        out_ready = 1'b0;
        capture(8'b1000_0010);
        for (int i = 0; i < 3; i++) begin
            check("bp_idx", out_lines, 1);
            check("bp_last", out_last, 0);
            check("bp_valid", out_valid, 1);
            if (i < 2) step();
        end
        out_ready = 1'b1;
        step();
        check("bp_idx_hi", out_lines, 7);
        check("bp_last_hi", out_last, 1);
        step();
        check("bp_done_valid", out_valid, 0);

        capture(8'h00);
        check("zero_err_pulse", zero_err, 1);
        check("zero_out_valid", out_valid, 0);
        check("zero_in_ready", in_ready, 1);
        check("zero_busy", busy, 0);
`ifdef ENC_ONEHOT_CHK_EN
        check("zero_onehot_err", onehot_err, 0);
`endif
        step();
        check("zero_err_clear", zero_err, 0);
        check("zero_after_valid", out_valid, 0);

        capture(8'b1000_0000);
        check("msb_idx", out_lines, 7);
        check("msb_last", out_last, 1);
`ifdef ENC_ONEHOT_CHK_EN
        check("msb_onehot_err", onehot_err, 0);
`endif
        step();
        check("msb_done_valid", out_valid, 0);

        capture(8'b1111_0000);
        check("mid_idx4", out_lines, 4);
        step();
        check("mid_idx5", out_lines, 5);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_after_valid", out_valid, 0);
            check("mid_after_busy", busy, 0);
            check("mid_after_in_ready", in_ready, 1);
        end
        capture(8'b0000_0001);
        check("new_valid", out_valid, 1);
        check("new_idx", out_lines, 0);
        check("new_last", out_last, 1);
        step();
        check("new_done_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_scan_n.md
Name: encoder_scan_n

Overview:
Parametrised N-to-log2(N) sequential encoder, the successor to the combinational 4-to-2 encoder. It accepts any input vector, not just one-hot. It captures the vector with a valid/ready handshake, then emits the index of every set bit, lowest first, one per accepted output beat. Typical use: it sits between a request/flag collector and a downstream consumer that services one line number at a time.

Parameters:
N_LINES, 8, number of input lines; must be >= 2 and a power of 2.
OUT_WIDTH, 3, width of out_lines; must equal log2(N_LINES). The block does not check this.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_lines  input  N_LINES  input line vector; sampled only on input handshake
in_valid  input  1  in_lines valid this cycle
in_ready  output  1  block can capture a vector this cycle
out_lines  output  OUT_WIDTH  encoded index of current lowest pending set bit
out_valid  output  1  out_lines valid
out_ready  input  1  consumer accepts out_lines this cycle
out_last  output  1  current out_lines is the final index of this vector
zero_err  output  1  one-cycle pulse: an all-zero vector was offered and accepted
busy  output  1  high while in SCAN state

Behaviour:
- State and registers:
  - States: IDLE, SCAN.
  - Registers: state, pending[N_LINES-1:0], zero_err.
  - All outputs are derived from these registers. There is no combinational in->out path.
- Reset (rst=1 at a clock edge):
  - state=IDLE, pending=0, zero_err=0.
  - While rst is high: in_ready=0, out_valid=0, out_lines=0, out_last=0, busy=0.
  - All handshakes are ignored while rst is high.
  - Reset mid-SCAN discards the pending bits. No further indices are emitted.
- IDLE:
  - in_ready=1, out_valid=0, out_lines=0, out_last=0, busy=0.
  - Input handshake = in_valid & in_ready at a clock edge.
  - Handshake with in_lines != 0: pending<=in_lines, state<=SCAN.
  - Handshake with in_lines == 0: zero_err<=1 for exactly one cycle; state stays IDLE; in_ready stays 1.
- SCAN:
  - in_ready=0, busy=1, out_valid=1. in_valid is ignored and no new vector is captured.
  - out_lines = index of lowest set bit of pending (bit 0 has highest priority).
  - out_last=1 iff pending has exactly one bit set.
  - Output handshake = out_valid & out_ready at a clock edge: clear that bit in pending.
  - If out_last was 1 at the handshake: state<=IDLE. in_ready returns to 1 the next cycle.
  - With out_ready=0: out_lines, out_last and pending hold unchanged, for any number of cycles.
- Timing:
  - Input handshake at edge k -> out_valid=1 from cycle k+1.
  - Throughput: 1 index per cycle with out_ready tied high.
  - A vector with P set bits takes P cycles in SCAN plus 1 cycle back in IDLE before the next capture.
- Index width: out_lines is zero-extended binary. A set bit at position N_LINES-1 encodes to all ones.
- zero_err: cleared on the cycle after it was set, unless another zero vector is accepted that cycle.

Optional Feature:
Macro ENC_ONEHOT_CHK_EN.
- Defined: adds output port onehot_err (1 bit, reset 0).
  - Pulses 1 for exactly one cycle (cycle k+1) when a handshake at edge k captures a vector with 2 or more bits set.
  - Scanning behaviour is unchanged.
  - onehot_err is never raised for zero or single-bit vectors.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
(N_LINES=8, OUT_WIDTH=3)
1. Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_lines=0, zero_err=0. After rst=0: in_ready=1 and nothing captured.
2. Single bit: in_lines=8'b0000_1000 for one handshake, out_ready=1 -> next cycle out_valid=1, out_lines=3, out_last=1. Following cycle out_valid=0, in_ready=1.
3. Multi bit: in_lines=8'b1010_0101, out_ready=1 -> out_lines=0,2,5,7 on 4 consecutive cycles; out_last=1 only with 7. in_valid held high during SCAN is ignored. onehot_err pulses once if ENC_ONEHOT_CHK_EN is defined.
4. Backpressure: in_lines=8'b1000_0010, out_ready=0 for 3 cycles -> out_lines holds 1, out_last=0. Then out_ready=1 -> 1 then 7 (out_last=1).
5. Zero vector: in_lines=0 with handshake -> zero_err=1 for one cycle, out_valid stays 0, in_ready stays 1, busy stays 0.
6. Reset mid-scan: in_lines=8'b1111_0000; after index 4 is accepted, assert rst for 1 cycle -> out_valid=0, busy=0 thereafter. No index 5/6/7 emitted. A new vector 8'b0000_0001 then yields out_lines=0, out_last=1.
